// File: rtl/mult32_seq_if.sv
// mult32_seq_if: operand/result bundle for the sequential 32x32 multiplier.
// The master drives the start strobe and operands; the slave (multiplier)
// returns status and the 64-bit product.
interface mult32_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult32_seq.sv
// mult32_seq: sequential 32x32 unsigned shift-add multiplier.
// One iteration per clock: conditionally add the multiplicand into the upper
// half of the accumulator (keeping the carry), then shift right by one.
// A start is accepted in IDLE or DONE; 32 iterations follow, then a one-cycle
// done pulse. The product register holds until the next accepted start's
// first iteration.
// Optional build macro: MULT_ZERO_BYPASS_EN -- a start with a zero operand
// completes immediately with product 0 and never raises busy.
module mult32_seq (
    input  logic          clk,
    input  logic          rst_n,
    mult32_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [64:0] p_q, p_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] product_q, product_d;
    logic [32:0] sum;

    // Next-state, datapath and iteration logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        // p_q[64] is the carry slot; it is zero whenever an add happens,
        // so this 33-bit add is the 32-bit add with its carry-out kept.
        sum = p_q[64:32] + (p_q[0] ? {1'b0, m_q} : 33'd0);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    m_d   = bus.a;
                    p_d   = {33'd0, bus.b};
                    cnt_d = 5'd0;
                    state_d = S_RUN;
`ifdef MULT_ZERO_BYPASS_EN
                    if ((bus.a == 32'd0) || (bus.b == 32'd0)) begin
                        p_d       = 65'd0;
                        product_d = 64'd0;
                        state_d   = S_DONE;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Carry enters bit 63 as the accumulator shifts right.
                p_d       = {1'b0, sum, p_q[31:1]};
                product_d = p_d[63:0];
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from values sampled at the same edge.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= 32'd0;
            p_q       <= 65'd0;
            cnt_q     <= 5'd0;
            product_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        bus.busy    = (state_q == S_RUN);
        bus.done    = (state_q == S_DONE);
        bus.product = product_q;
    end

endmodule

// File: doc/mult32_seq.md
# mult32_seq

Sequential 32×32 unsigned shift-add multiplier for the datapath's multiply path. It consumes 32-bit addition results: one add with carry-out per iteration accumulates the partial product. It accepts operands on a single-cycle start strobe and runs for 32 iterations. It returns a 64-bit product with a one-cycle done pulse, and holds the result until the next accepted start.

## Interface
- No parameters; operand width fixed at 32, product width 64.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request strobe; sampled on rising clk
- a  input  32  multiplicand (unsigned)
- b  input  32  multiplier (unsigned)
- busy  output  1  high while iterating (state RUN)
- done  output  1  one-cycle pulse, product valid
- product  output  64  result register {hi, lo}

One clock; reset is synchronous and active-low.

## Operation
- Internal registers:
  - M[31:0]: multiplicand.
  - P[64:0]: accumulator, with P[64] as the carry.
  - cnt[4:0]: iteration counter.
  - state: IDLE, RUN or DONE.
- IDLE / DONE + start=1:
  - Load M=a and P={33'b0, b}, cnt=0.
  - Go to RUN.
- IDLE / DONE + start=0:
  - DONE→IDLE; IDLE stays.
- RUN, each edge:
  - If P[0]=1: {c, s} = P[63:32] + M (32-bit add, carry-in 0), giving a 33-bit sum.
  - Else: {c, s} = {1'b0, P[63:32]}.
  - Update P = {1'b0, c, s, P[31:1]}, i.e. a logical right shift by 1 with the carry entering bit 63.
  - cnt += 1.
  - When cnt==31 on this edge, go to DONE.
- start while in RUN: ignored entirely; operands are not captured and the counter does not restart.
- product = P[63:0], registered. It updates only in RUN and holds in IDLE/DONE until the next accepted start.
- The adder carry-out must be kept. Dropping it corrupts results once the accumulator exceeds 2^32−1.
- Reset (rst_n=0 at an edge, in any state, including mid-RUN): state=IDLE, P=0, M=0, cnt=0. Any operation in progress is abandoned with no done pulse.

## Timing
- Reset values: busy=0, done=0, product=64'h0.
- Start accepted at edge E0.
- Iterations occur at edges E1..E32.
- busy=1 in the cycles following E0 through E31.
- At E32, state becomes DONE:
  - done=1 for exactly one cycle, the cycle after E32.
  - busy=0 in that same cycle.
  - product is final in that same cycle.
- Latency from start edge to done: 33 cycles; one result every 33 cycles with back-to-back starts.
- A start asserted during the DONE cycle is accepted at E33:
  - done is still 1 in the DONE cycle itself.
  - busy=1 in the following cycle.
  - product keeps the old result until E34, the first iteration.
- A start held high across multiple cycles:
  - Accepted once.
  - Re-accepted only if still high in the DONE cycle.
- busy and done are never high simultaneously.

## Configuration
- MULT_ZERO_BYPASS_EN
  - **Defined:** at an accepted start with a==0 or b==0:
    - Load P=0 and go directly to DONE.
    - done=1 in the cycle after E0; product=0.
    - busy never asserts.
    - Nonzero operands behave as in the non-bypass case.
  - **Undefined:** all operations take the full 33-cycle latency, including zero operands.

## Test plan
- Reset, then start with a=3, b=5 → busy for 32 cycles; done pulse 33 cycles after the start edge; product=64'h0000_0000_0000_000F, held afterwards.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → product=64'hFFFF_FFFE_0000_0001. This exercises the carry path.
- Start a=7, b=9. Ten cycles later, pulse start with a=2, b=2 → second request ignored; product=63 at done with the same 33-cycle latency.
- Start a=6, b=7. At cycle 15, rst_n=0 for one edge → busy=0, product=0, no done pulse. A subsequent start a=4, b=4 gives product=16.
- Start a=10, b=20; reassert start in the done cycle with a=100, b=3 → first done shows 200; second done 33 cycles later shows 300.
- MULT_ZERO_BYPASS_EN defined: start a=0, b=12345 → done in the cycle after start, product=0, busy stays 0. With the macro undefined, the same stimulus gives done after 33 cycles, product=0.
